serial_to_parallel: RTL
=======================

// Module: serial_to_parallel
// PURPOSE
//   Deserializer stage that sits directly downstream of the parallel-to-serial serializer.
//   - Consumes the serializer's LSB-first bit stream (serial_o/valid_o -> serial_i/valid_i).
//   - Reassembles WIDTH-bit words and presents them on a valid/ready parallel output.
//   - Flags overrun (word lost to backpressure) and partial frames abandoned by a gap timeout.
// PARAMETERS
//   WIDTH    4   word width in bits; legal range 2..32
//   TIMEOUT  8   idle cycles (valid_i=0) mid-frame before the partial word is discarded; 0 = never
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high reset
//   serial_i     in   1      serial data bit, LSB of the word first
//   valid_i      in   1      serial_i holds a valid bit this cycle
//   ready_i      in   1      downstream accepts parallel_o this cycle
//   parallel_o   out  WIDTH  assembled word; stable while valid_o=1
//   valid_o      out  1      parallel_o holds an unconsumed word
//   busy_o       out  1      partial frame in progress (bit_cnt != 0)
//   overrun_o    out  1      1-cycle pulse: completed word dropped because output register full
//   frame_err_o  out  1      1-cycle pulse: partial frame discarded by timeout
// BEHAVIOUR
//   Reset (async assert, deassert on any edge):
//   - All outputs 0; shift register, bit_cnt and gap counter cleared.
//   - Asserting mid-frame or mid-hold drops all data immediately, with no error pulse.
//   Shift side (states IDLE: bit_cnt==0 / SHIFT: bit_cnt!=0):
//   - Each edge with valid_i=1: shreg[bit_cnt] <= serial_i; bit_cnt++; gap counter <= 0.
//   - Edge with valid_i=1 and bit_cnt==WIDTH-1: word complete; bit_cnt wraps to 0 (IDLE).
//   - SHIFT with valid_i=0: gap counter++. When gap counter reaches TIMEOUT:
//     bit_cnt <= 0, shreg <= 0, frame_err_o=1 for exactly 1 cycle.
//   - Gaps shorter than TIMEOUT are transparent. IDLE never times out.
//   Output side (states EMPTY: valid_o=0 / FULL: valid_o=1):
//   - Handshake completes on any edge where valid_o && ready_i; ready_i is ignored when valid_o=0.
//   - Complete word while EMPTY: parallel_o <= {serial_i, shreg[WIDTH-2:0]}; valid_o=1 after that
//     same edge. Latency is 0 cycles after the last bit's sampling edge.
//   - Complete word while FULL and ready_i=1: same-cycle drain and reload.
//     parallel_o takes the new word, valid_o stays 1, no overrun.
//   - Complete word while FULL and ready_i=0: new word dropped; parallel_o and valid_o unchanged;
//     overrun_o=1 for 1 cycle.
//   - Handshake with no completing word: valid_o <= 0. parallel_o holds its last value
//     (don't-care while valid_o=0).
//   - valid_o and parallel_o never change while valid_o=1 && ready_i=0, except through the
//     drain-and-reload case above.
//   - Timeout and word completion are mutually exclusive, since completion requires valid_i=1.
//   Invariants:
//   - overrun_o and frame_err_o never assert in the same cycle.
//   - busy_o == (bit_cnt != 0).
// TESTING
//   1 Reset: hold reset 2 cycles -> all outputs 0. Assert reset after 2 bits of a frame ->
//     outputs 0 immediately; the next 4 bits form a clean word.
//   2 Basic, WIDTH=4, ready_i=1: bits 0,1,0,1 on consecutive cycles -> valid_o=1 with
//     parallel_o=4'hA right after the 4th edge, low one cycle later.
//   3 Backpressure, ready_i=0: send 4'hF then 4'h3 -> parallel_o holds 4'hF, overrun_o pulses
//     once at the 2nd word's last bit. Raise ready_i -> 4'hF consumed, valid_o=0.
//   4 Simultaneous: ready_i=1 on the edge completing 4'h6 while 4'h9 is held -> 4'h9 consumed,
//     parallel_o=4'h6, valid_o stays 1, overrun_o stays 0.
//   5 Timeout, TIMEOUT=8: 2 bits, 7-cycle gap, 2 bits -> word OK, no frame_err_o.
//     2 bits then an 8-cycle gap -> frame_err_o pulse, busy_o=0; the next 4 bits form a fresh word.
//   6 Loopback: chain the serializer into this block, drive 4'b1010, 4'b1111 and 5 random words
//     -> every word reappears on parallel_o in order; overrun_o and frame_err_o never assert.

Source files
------------

// File: rtl/serial_to_parallel.sv
// Deserializer: rebuilds LSB-first serial words into WIDTH-bit parallel words on a
// valid/ready output, flagging words lost to backpressure and frames abandoned by a gap.
module serial_to_parallel #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_i,
  input  logic             valid_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] parallel_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             frame_err_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (TIMEOUT > 0) ? GW'(TIMEOUT - 1) : '0;

  typedef enum logic {S_IDLE,  S_SHIFT} shift_state_t;
  typedef enum logic {S_EMPTY, S_FULL}  out_state_t;

  shift_state_t     shift_state;
  out_state_t       out_state, out_nxt;

  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] parallel_q, parallel_nxt;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             load;
  logic             frame_err_nxt;
  logic             overrun_nxt;

  // Shift-side registers; the IDLE/SHIFT state is implied by a non-zero bit count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt_nxt;
      gap_cnt     <= gap_nxt;
      shreg       <= shreg_nxt;
      frame_err_o <= frame_err_nxt;
    end
  end

  assign shift_state = (bit_cnt == '0) ? S_IDLE : S_SHIFT;
  assign word        = {serial_i, shreg[WIDTH-2:0]};

  always_comb begin
    bit_cnt_nxt   = bit_cnt;
    gap_nxt       = gap_cnt;
    shreg_nxt     = shreg;
    frame_err_nxt = 1'b0;
    word_done     = 1'b0;
    if (valid_i) begin
      shreg_nxt[bit_cnt] = serial_i;
      gap_nxt            = '0;
      if (bit_cnt == LAST_BIT) begin
        bit_cnt_nxt = '0;
        word_done   = 1'b1;
      end else begin
        bit_cnt_nxt = bit_cnt + 1'b1;
      end
    end else if (shift_state == S_SHIFT && TIMEOUT != 0) begin
      // A stalled partial frame is thrown away once the gap reaches TIMEOUT idle cycles.
      if (gap_cnt == GAP_LAST) begin
        bit_cnt_nxt   = '0;
        shreg_nxt     = '0;
        gap_nxt       = '0;
        frame_err_nxt = 1'b1;
      end else begin
        gap_nxt = gap_cnt + 1'b1;
      end
    end
  end

  // Output-side state register, including the held word and the overrun pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state  <= S_EMPTY;
      parallel_q <= '0;
      overrun_o  <= 1'b0;
    end else begin
      out_state  <= out_nxt;
      parallel_q <= parallel_nxt;
      overrun_o  <= overrun_nxt;
    end
  end

  // A completing word while FULL reloads only if the held word drains on the same edge.
  always_comb begin
    out_nxt     = out_state;
    load        = 1'b0;
    overrun_nxt = 1'b0;
    case (out_state)
      S_EMPTY: begin
        if (word_done) begin
          load    = 1'b1;
          out_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (word_done) begin
          if (ready_i) load = 1'b1;
          else         overrun_nxt = 1'b1;
        end else if (ready_i) begin
          out_nxt = S_EMPTY;
        end
      end
      default: out_nxt = S_EMPTY;
    endcase
    parallel_nxt = load ? word : parallel_q;
  end

  always_comb begin
    valid_o    = (out_state == S_FULL);
    parallel_o = parallel_q;
    busy_o     = (shift_state == S_SHIFT);
  end

  a_pulses_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(overrun_o && frame_err_o));

endmodule
